// File: rtl/mod_counter.sv
// WIDTH-bit up/down event counter: runtime modulo limit, synchronous load,
// wrap or saturate at the boundary, enable prescaler, terminal pulse, sticky overflow.
module mod_counter #(
    parameter int               WIDTH     = 8,
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal,
    output logic             overflow
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [PS_W-1:0]  presc;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] cnt_next;

    assign step = enable && (presc == PS_LAST);

    // Up boundary uses >= so an out-of-range loaded value is treated as the top.
    always_comb begin
        boundary = 1'b0;
        cnt_next = counter_out;
        if (up_down) begin
            if (counter_out >= limit) begin
                boundary = 1'b1;
                cnt_next = sat_mode ? limit : '0;
            end else begin
                cnt_next = counter_out + ONE;
            end
        end else begin
            if (counter_out == '0) begin
                boundary = 1'b1;
                cnt_next = sat_mode ? '0 : limit;
            end else begin
                cnt_next = counter_out - ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_out <= RESET_VAL;
            presc       <= '0;
            terminal    <= 1'b0;
            overflow    <= 1'b0;
        end else if (load) begin
            counter_out <= load_value;
            presc       <= '0;
            terminal    <= 1'b0;
            overflow    <= overflow && !clear_ovf;
        end else begin
            if (enable)
                presc <= step ? '0 : presc + PS_W'(1);
            if (step)
                counter_out <= cnt_next;
            terminal <= step && boundary;
            // A boundary step in the same cycle beats clear_ovf.
            overflow <= (step && boundary) || (overflow && !clear_ovf);
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: two instances (PRESCALE 1 and 3) share stimulus,
// a behavioural model pushes expected outputs per cycle, popped after each edge.
module tb_mod_counter;

    logic       clock = 1'b0;
    logic       reset, enable, up_down, sat_mode, load, clear_ovf;
    logic [7:0] limit, load_value;
    logic [7:0] cnt_a;
    logic       term_a, ovf_a;
    logic [3:0] cnt_b;
    logic       term_b, ovf_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mod_counter #(.WIDTH(8), .PRESCALE(1), .RESET_VAL(8'd0)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .limit(limit), .load(load), .load_value(load_value),
        .clear_ovf(clear_ovf), .counter_out(cnt_a), .terminal(term_a), .overflow(ovf_a)
    );

    mod_counter #(.WIDTH(4), .PRESCALE(3), .RESET_VAL(4'd3)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .limit(limit[3:0]), .load(load), .load_value(load_value[3:0]),
        .clear_ovf(clear_ovf), .counter_out(cnt_b), .terminal(term_b), .overflow(ovf_b)
    );

    typedef struct {
        int c_a; int t_a; int o_a;
        int c_b; int t_b; int o_b;
    } exp_t;

    exp_t exp_q[$];

    // model state, index 0 = u_a, 1 = u_b
    int m_cnt[2], m_ps[2], m_term[2], m_ovf[2];
    int m_mask[2] = '{255, 15};
    int m_pre[2]  = '{1, 3};
    int m_rst[2]  = '{0, 3};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input int i, input bit rst, en, ud, sat, ld, clr,
                         input int lim_in, lv_in);
        int lim, fire, bnd;
        lim = lim_in & m_mask[i];
        if (rst) begin
            m_cnt[i] = m_rst[i]; m_ps[i] = 0; m_term[i] = 0; m_ovf[i] = 0;
        end else if (ld) begin
            m_cnt[i] = lv_in & m_mask[i]; m_ps[i] = 0; m_term[i] = 0;
            m_ovf[i] = m_ovf[i] & ~int'(clr);
        end else begin
            fire = (en && (m_ps[i] + 1 == m_pre[i])) ? 1 : 0;
            if (en) m_ps[i] = fire ? 0 : m_ps[i] + 1;
            bnd = 0;
            if (fire) begin
                if (ud) begin
                    if (m_cnt[i] >= lim) begin bnd = 1; m_cnt[i] = sat ? lim : 0; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    if (m_cnt[i] == 0) begin bnd = 1; m_cnt[i] = sat ? 0 : lim; end
                    else m_cnt[i] = m_cnt[i] - 1;
                end
            end
            m_term[i] = bnd;
            m_ovf[i]  = (bnd || (m_ovf[i] && !clr)) ? 1 : 0;
        end
    endtask

    // Drive one cycle on the falling edge, predict, then compare after the rising edge.
    task automatic cyc(input bit rst, en, ud, sat, input int lim, input bit ld,
                       input int lv, input bit clr);
        exp_t e;
        @(negedge clock);
        reset = rst; enable = en; up_down = ud; sat_mode = sat;
        limit = 8'(lim); load = ld; load_value = 8'(lv); clear_ovf = clr;
        for (int i = 0; i < 2; i++) model(i, rst, en, ud, sat, ld, clr, lim, lv);
        e.c_a = m_cnt[0]; e.t_a = m_term[0]; e.o_a = m_ovf[0];
        e.c_b = m_cnt[1]; e.t_b = m_term[1]; e.o_b = m_ovf[1];
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("cnt_a", int'(cnt_a), e.c_a);
            chk("term_a", int'(term_a), e.t_a);
            chk("ovf_a", int'(ovf_a), e.o_a);
            chk("cnt_b", int'(cnt_b), e.c_b);
            chk("term_b", int'(term_b), e.t_b);
            chk("ovf_b", int'(ovf_b), e.o_b);
        end
    endtask

    initial begin
        int nterm;
        int seq[3];
        reset = 1; enable = 0; up_down = 1; sat_mode = 0; limit = 0;
        load = 0; load_value = 0; clear_ovf = 0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_ps[i] = 0; m_term[i] = 0; m_ovf[i] = 0; end

        // reset state
        cyc(1, 0, 1, 0, 15, 0, 0, 0);
        cyc(1, 1, 1, 0, 15, 0, 0, 0);
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_cnt_b", int'(cnt_b), 3);

        // full-range wrap up: one terminal pulse at 15->0
        nterm = 0;
        for (int k = 0; k < 17; k++) begin
            cyc(0, 1, 1, 0, 15, 0, 0, 0);
            nterm += int'(term_a);
        end
        chk("t1_terms", nterm, 1);
        chk("t1_cnt", int'(cnt_a), 1);
        chk("t1_ovf", int'(ovf_a), 1);

        // saturate up at 9: steps 10..12 pulse terminal
        cyc(1, 0, 1, 1, 9, 0, 0, 0);
        nterm = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 1, 1, 9, 0, 0, 0);
            nterm += int'(term_a);
        end
        chk("t2_terms", nterm, 3);
        chk("t2_cnt", int'(cnt_a), 9);
        cyc(0, 0, 0, 1, 9, 1, 0, 0);
        cyc(0, 1, 0, 1, 9, 0, 0, 0);
        chk("t2_dn_hold", int'(cnt_a), 0);
        chk("t2_dn_term", int'(term_a), 1);

        // prescaler with enable gaps
        cyc(1, 0, 1, 0, 9, 0, 0, 0);
        cyc(0, 1, 1, 0, 9, 0, 0, 0);
        cyc(0, 1, 1, 0, 9, 0, 0, 0);
        chk("t3_b_wait", int'(cnt_b), 3);
        cyc(0, 0, 1, 0, 9, 0, 0, 0);
        chk("t3_b_held", int'(cnt_b), 3);
        cyc(0, 1, 1, 0, 9, 0, 0, 0);
        chk("t3_b_step", int'(cnt_b), 4);

        // load beats enable; out-of-range value wraps, then clamps in sat
        cyc(0, 1, 1, 0, 50, 1, 200, 0);
        chk("t4_load", int'(cnt_a), 200);
        cyc(0, 1, 1, 0, 50, 0, 0, 0);
        chk("t4_wrap", int'(cnt_a), 0);
        chk("t4_term", int'(term_a), 1);
        cyc(0, 1, 1, 1, 50, 1, 200, 0);
        cyc(0, 1, 1, 1, 50, 0, 0, 0);
        chk("t4_clamp", int'(cnt_a), 50);

        // down wrap from 1 with limit 5; clear_ovf loses to a boundary step
        cyc(0, 0, 0, 0, 5, 0, 0, 1);
        cyc(0, 0, 0, 0, 5, 1, 1, 0);
        cyc(0, 1, 0, 0, 5, 0, 0, 0); seq[0] = int'(cnt_a);
        cyc(0, 1, 0, 0, 5, 0, 0, 1); seq[1] = int'(cnt_a);
        chk("t5_term", int'(term_a), 1);
        chk("t5_ovf_set_wins", int'(ovf_a), 1);
        cyc(0, 1, 0, 0, 5, 0, 0, 0); seq[2] = int'(cnt_a);
        chk("t5_s0", seq[0], 0);
        chk("t5_s1", seq[1], 5);
        chk("t5_s2", seq[2], 4);
        cyc(0, 0, 0, 0, 5, 0, 0, 1);
        chk("t5_clr", int'(ovf_a), 0);

        // reset with pending load mid-count
        cyc(0, 0, 1, 0, 20, 1, 0, 0);
        for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 20, 0, 0, 0);
        chk("t6_pre", int'(cnt_a), 7);
        cyc(1, 1, 1, 0, 20, 1, 99, 0);
        chk("t6_cnt", int'(cnt_a), 0);
        chk("t6_ovf", int'(ovf_a), 0);
        chk("t6_term", int'(term_a), 0);
        cyc(0, 1, 1, 0, 20, 0, 0, 0);
        chk("t6_resume", int'(cnt_a), 1);

        // limit 0: every step is a boundary
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 0);
            chk("lim0_term", int'(term_a), 1);
        end

        // random mix, model-checked
        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom), $urandom_range(0, 255),
                ($urandom_range(0, 15) == 0), $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0));

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
